err_inject_apply: RTL and testbench

// - Datapath stage directly downstream of the error-injection controller. Consumes its

---
 rtl/err_inject_apply_if.sv | 24 ++
 rtl/err_inject_apply.sv | 175 +++++++++++++++++
 tb/tb_err_inject_apply.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/err_inject_apply_if.sv
// rtl/err_inject_apply_if.sv - input/output beat stream bundle for err_inject_apply
interface err_inject_apply_if #(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_corrupt;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_corrupt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_corrupt
    );
endinterface

// File: rtl/err_inject_apply.sv
// rtl/err_inject_apply.sv - XORs the injector mask onto a stream beat, counts and logs corrupted beats
// Optional ERR_APPLY_PARITY_EN adds out_par, the parity of the original (uncorrupted) beat.
module err_inject_apply #(
    parameter int DATA_W    = 128,
    parameter int LOG_DEPTH = 8,
    parameter int BEAT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    err_inject_apply_if.slave     s,
    input  logic [DATA_W-1:0]     err_mask,
    input  logic [1:0]            apply_mode,
    output logic [15:0]           corrupt_cnt,
    output logic                  log_valid,
    output logic [16+BEAT_W-1:0]  log_data,
    input  logic                  log_pop,
    output logic                  log_ovf
`ifdef ERR_APPLY_PARITY_EN
    ,
    output logic                  out_par
`endif
);
    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam logic [1:0] MODE_CONT    = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd1;
    localparam logic [1:0] MODE_PACKET  = 2'd2;
    localparam logic [PTR_W:0]    PTR_ONE  = 1;
    localparam logic [BEAT_W-1:0] BEAT_ONE = 1;

    typedef enum logic [1:0] {IDLE, ARMED, INJ, SPENT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mask_q;
    logic [15:0]         pkt_num;
    logic [BEAT_W-1:0]   beat_idx;
    logic [PTR_W:0]      wr_ptr;
    logic [PTR_W:0]      rd_ptr;
    logic [16+BEAT_W-1:0] log_mem [LOG_DEPTH];

    logic mask_nz;
    logic acc;
    logic corrupt;
    logic fifo_empty;
    logic fifo_full;
    logic pop_ok;
    logic push_ok;

    assign s.in_ready = !s.out_valid || s.out_ready;
    assign mask_nz    = |err_mask;
    assign acc        = s.in_valid && s.in_ready;

    // Gating uses the live mask so a beat taken while the mask drops is left clean.
    always_comb begin
        corrupt = 1'b0;
        if (acc && mask_nz) begin
            case (state)
                ARMED: corrupt = (apply_mode == MODE_CONT) || (apply_mode == MODE_ONESHOT) ||
                                 ((apply_mode == MODE_PACKET) && (beat_idx == '0));
                INJ:   corrupt = 1'b1;
                default: corrupt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mask_q <= '0;
        end else if (state == IDLE) begin
            if (mask_nz) begin
                state  <= ARMED;
                mask_q <= err_mask;
            end
        end else if (!mask_nz) begin
            state <= IDLE;
        end else begin
            case (state)
                ARMED: begin
                    if (acc) begin
                        if (apply_mode == MODE_ONESHOT) begin
                            state <= SPENT;
                        end else if ((apply_mode == MODE_PACKET) && (beat_idx == '0)) begin
                            state <= s.in_last ? SPENT : INJ;
                        end
                    end
                end
                INJ: begin
                    if (acc && s.in_last) begin
                        state <= SPENT;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.out_valid   <= 1'b0;
            s.out_data    <= '0;
            s.out_last    <= 1'b0;
            s.out_corrupt <= 1'b0;
        end else if (acc) begin
            s.out_valid   <= 1'b1;
            s.out_data    <= corrupt ? (s.in_data ^ mask_q) : s.in_data;
            s.out_last    <= s.in_last;
            s.out_corrupt <= corrupt;
        end else if (s.out_ready) begin
            s.out_valid <= 1'b0;
        end
    end

`ifdef ERR_APPLY_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par <= 1'b0;
        end else if (acc) begin
            out_par <= ^s.in_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_num     <= '0;
            beat_idx    <= '0;
            corrupt_cnt <= '0;
        end else begin
            if (acc) begin
                if (s.in_last) begin
                    beat_idx <= '0;
                    pkt_num  <= pkt_num + 16'd1;
                end else if (beat_idx != '1) begin
                    beat_idx <= beat_idx + BEAT_ONE;
                end
            end
            if (corrupt && (corrupt_cnt != 16'hFFFF)) begin
                corrupt_cnt <= corrupt_cnt + 16'd1;
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_ok     = log_pop && !fifo_empty;
    assign push_ok    = corrupt && (!fifo_full || pop_ok);
    assign log_valid  = !fifo_empty;
    assign log_data   = log_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            log_ovf <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (corrupt && fifo_full && !pop_ok) begin
                log_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            log_mem[wr_ptr[PTR_W-1:0]] <= {pkt_num, beat_idx};
        end
    end
endmodule

// File: tb/tb_err_inject_apply.sv
// tb/tb_err_inject_apply.sv - self-checking bench for err_inject_apply
module tb_err_inject_apply;
    localparam int DW = 128;
    localparam int BW = 8;
    localparam int LD = 8;
    localparam logic [DW-1:0] M_PKT = 128'hDEADBEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    err_inject_apply_if #(.DATA_W(DW)) bus ();
    logic [DW-1:0] err_mask = '0;
    logic [1:0]    apply_mode = 2'd0;
    logic [15:0]   corrupt_cnt;
    logic          log_valid;
    logic [23:0]   log_data;
    logic          log_pop = 1'b0;
    logic          log_ovf;
`ifdef ERR_APPLY_PARITY_EN
    logic          out_par;
`endif

    err_inject_apply #(.DATA_W(DW), .LOG_DEPTH(LD), .BEAT_W(BW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (bus.slave),
        .err_mask    (err_mask),
        .apply_mode  (apply_mode),
        .corrupt_cnt (corrupt_cnt),
        .log_valid   (log_valid),
        .log_data    (log_data),
        .log_pop     (log_pop),
        .log_ovf     (log_ovf)
`ifdef ERR_APPLY_PARITY_EN
        ,
        .out_par     (out_par)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state after the most recent clock edge plus "mask run" bookkeeping.
    bit            m_ov, m_ol, m_oc, m_par, m_ovf;
    logic [DW-1:0] m_od;
    int            m_cnt, m_pkt, m_beat;
    logic [23:0]   m_log[$];
    bit            prev_nz, used, inj;
    int            run_idx;
    logic [DW-1:0] run_mask;

    task automatic model_reset();
        m_ov = 0; m_ol = 0; m_oc = 0; m_par = 0; m_ovf = 0; m_od = '0;
        m_cnt = 0; m_pkt = 0; m_beat = 0; m_log.delete();
        prev_nz = 0; used = 0; inj = 0; run_idx = 0; run_mask = '0;
    endtask

    task automatic check_outputs();
        chk("out_valid", bus.out_valid, m_ov);
        chk("out_data", bus.out_data, m_od);
        chk("out_last", bus.out_last, m_ol);
        chk("out_corrupt", bus.out_corrupt, m_oc);
        chk("corrupt_cnt", corrupt_cnt, m_cnt);
        chk("log_valid", log_valid, m_log.size() > 0);
        if (m_log.size() > 0) chk("log_data", log_data, m_log[0]);
        chk("log_ovf", log_ovf, m_ovf);
`ifdef ERR_APPLY_PARITY_EN
        chk("out_par", out_par, m_par);
`endif
    endtask

    task automatic cycle(input logic [DW-1:0] mask, input logic [1:0] mode, input bit v,
                         input logic [DW-1:0] d, input bit l, input bit ordy, input bit pop,
                         output bit acc);
        bit nz, ready, corrupt, pop_eff, full_b;
        @(negedge clk);
        check_outputs();
        err_mask = mask; apply_mode = mode; bus.in_valid = v; bus.in_data = d;
        bus.in_last = l; bus.out_ready = ordy; log_pop = pop;
        #1;
        nz = |mask;
        if (nz) begin
            if (prev_nz) run_idx++;
            else begin run_idx = 0; run_mask = mask; used = 0; inj = 0; end
        end else begin
            inj = 0;
        end
        prev_nz = nz;
        ready = !m_ov || ordy;
        chk("in_ready", bus.in_ready, ready);
        acc = v && ready;
        corrupt = 0;
        // Corruption needs the mask to have been up for at least one earlier cycle of this run.
        if (acc && nz && run_idx >= 1) begin
            if (inj) begin
                corrupt = 1;
                if (l) begin inj = 0; used = 1; end
            end else if (!used) begin
                case (mode)
                    2'd0: corrupt = 1;
                    2'd1: begin corrupt = 1; used = 1; end
                    2'd2: if (m_beat == 0) begin corrupt = 1; if (l) used = 1; else inj = 1; end
                    default: corrupt = 0;
                endcase
            end
        end
        pop_eff = pop && (m_log.size() > 0);
        full_b = (m_log.size() == LD);
        if (pop_eff) void'(m_log.pop_front());
        if (corrupt) begin
            if (!full_b || pop_eff) m_log.push_back({m_pkt[15:0], m_beat[7:0]});
            else m_ovf = 1;
            if (m_cnt < 65535) m_cnt++;
        end
        if (acc) begin
            m_ov = 1; m_od = corrupt ? (d ^ run_mask) : d; m_ol = l; m_oc = corrupt; m_par = ^d;
            if (l) begin m_beat = 0; m_pkt = (m_pkt + 1) % 65536; end
            else if (m_beat < 255) m_beat++;
        end else if (ordy) begin
            m_ov = 0;
        end
        @(posedge clk);
    endtask

    task automatic send(input logic [DW-1:0] mask, input logic [1:0] mode, input logic [DW-1:0] d,
                        input bit l);
        bit acc;
        for (int t = 0; t < 16; t++) begin
            cycle(mask, mode, 1'b1, d, l, 1'b1, 1'b0, acc);
            if (acc) return;
        end
        checks++; failures++;
        $display("FAIL send_timeout: beat %0h not accepted within 16 cycles", d);
    endtask

    task automatic idle(input logic [DW-1:0] mask, input logic [1:0] mode, input bit pop);
        bit acc;
        cycle(mask, mode, 1'b0, '0, 1'b0, 1'b1, pop, acc);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_in_ready", bus.in_ready, 1'b1);
        repeat (hold) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        bit            rst_before;
        logic [DW-1:0] mask;
        logic [1:0]    mode;
        bit            v;
        logic [DW-1:0] d;
        bit            l;
        bit            exp_v;
        logic [DW-1:0] exp_d;
        bit            exp_c;
        int            exp_cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int accepted, delivered;
        logic [DW-1:0] nd, cur_mask;
        logic [23:0] exp_log;

        // Bypass beats 1..4, then one-shot F0,F1,F2 with mask 1 after a fresh reset.
        for (int k = 0; k < 4; k++)
            tbl[k] = '{0, '0, 2'd0, 1, DW'(k + 1), 0, 1, DW'(k + 1), 0, 0};
        tbl[4] = '{1, DW'(1), 2'd1, 0, '0, 0, 0, '0, 0, 0};
        tbl[5] = '{0, DW'(1), 2'd1, 1, DW'('hF0), 0, 1, DW'('hF1), 1, 1};
        tbl[6] = '{0, DW'(1), 2'd1, 1, DW'('hF1), 0, 1, DW'('hF1), 0, 1};
        tbl[7] = '{0, DW'(1), 2'd1, 1, DW'('hF2), 1, 1, DW'('hF2), 0, 1};

        bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0;
        model_reset();
        do_reset(2);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst_before) do_reset(2);
            cycle(tbl[i].mask, tbl[i].mode, tbl[i].v, tbl[i].d, tbl[i].l, 1'b1, 1'b0, acc);
            #1;
            chk("tbl_valid", bus.out_valid, tbl[i].exp_v);
            if (tbl[i].exp_v) begin
                chk("tbl_data", bus.out_data, tbl[i].exp_d);
                chk("tbl_corrupt", bus.out_corrupt, tbl[i].exp_c);
            end
            chk("tbl_cnt", corrupt_cnt, tbl[i].exp_cnt);
        end
        chk("oneshot_log_valid", log_valid, 1'b1);
        chk("oneshot_log", log_data, 24'h000000);
        idle('0, 2'd1, 1'b1);

        // Packet mode armed mid-packet: packet 0 passes clean, packet 1 is fully corrupted.
        do_reset(2);
        send('0, 2'd2, DW'('hA0), 0);
        send('0, 2'd2, DW'('hA1), 0);
        send(M_PKT, 2'd2, DW'('hA2), 0);
        send(M_PKT, 2'd2, DW'('hA3), 1);
        send(M_PKT, 2'd2, '0, 0);
        send(M_PKT, 2'd2, '0, 0);
        send(M_PKT, 2'd2, '0, 1);
        #1 chk("pkt_last_data", bus.out_data, M_PKT);
        idle(M_PKT, 2'd2, 1'b0);
        #1 chk("pkt_cnt", corrupt_cnt, 16'd3);
        for (int i = 0; i < 3; i++) begin
            exp_log = {16'd1, 8'(i)};
            #1 chk("pkt_log", log_data, exp_log);
            idle(M_PKT, 2'd2, 1'b1);
        end
        #1 chk("pkt_log_empty", log_valid, 1'b0);

        // Continuous mode with a five-cycle output stall.
        do_reset(2);
        idle(DW'('h55), 2'd0, 1'b0);
        nd = DW'(100); accepted = 0; delivered = 0;
        for (int k = 0; k < 12; k++) begin
            bit ordy;
            ordy = !(k >= 3 && k < 8);
            if (m_ov && ordy) delivered++;
            cycle(DW'('h55), 2'd0, 1'b1, nd, 1'b0, ordy, 1'b0, acc);
            if (acc) begin accepted++; nd++; end
            if (k >= 4 && k < 8) begin
                #1 chk("stall_in_ready", bus.in_ready, 1'b0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (m_ov) delivered++;
            idle(DW'('h55), 2'd0, 1'b0);
        end
        #1;
        chk("bp_delivered", delivered, accepted);
        chk("bp_cnt", corrupt_cnt, delivered);

        // Log overflow: ten corrupted beats, no pops.
        do_reset(2);
        idle(DW'(3), 2'd0, 1'b0);
        for (int i = 0; i < LD + 2; i++) send(DW'(3), 2'd0, DW'(i), 0);
        idle(DW'(3), 2'd0, 1'b0);
        #1;
        chk("ovf_flag", log_ovf, 1'b1);
        chk("ovf_cnt", corrupt_cnt, LD + 2);
        for (int i = 0; i < LD; i++) begin
            exp_log = {16'd0, 8'(i)};
            #1 chk("ovf_log", log_data, exp_log);
            idle('0, 2'd0, 1'b1);
        end
        #1 chk("ovf_log_empty", log_valid, 1'b0);

        // Mask drop mid-packet, re-arm, then reset mid-packet.
        do_reset(2);
        idle(M_PKT, 2'd2, 1'b0);
        send(M_PKT, 2'd2, DW'('h10), 0);
        send(M_PKT, 2'd2, DW'('h11), 0);
        send('0, 2'd2, DW'('h12), 0);
        #1 chk("drop_clean", bus.out_corrupt, 1'b0);
        send('0, 2'd2, DW'('h13), 1);
        idle('0, 2'd2, 1'b0);
        #1 chk("drop_cnt", corrupt_cnt, 16'd2);
        idle(M_PKT, 2'd2, 1'b0);
        send(M_PKT, 2'd2, DW'('h20), 1);
        #1 chk("rearm_corrupt", bus.out_corrupt, 1'b1);
        send(M_PKT, 2'd2, DW'('h30), 0);
        send(M_PKT, 2'd2, DW'('h31), 0);
        do_reset(3);
        idle(M_PKT, 2'd2, 1'b0);
        send(M_PKT, 2'd2, DW'('h77), 0);
        #1;
        chk("post_rst_log_valid", log_valid, 1'b1);
        chk("post_rst_log", log_data, 24'h000000);
        chk("post_rst_cnt", corrupt_cnt, 16'd1);

        // Randomized traffic per mode against the model.
        for (int mode = 0; mode < 4; mode++) begin
            do_reset(1);
            cur_mask = rnd();
            for (int k = 0; k < 300; k++) begin
                if ($urandom_range(15) == 0)
                    cur_mask = ($urandom_range(2) == 0) ? '0 : rnd();
                cycle(cur_mask, 2'(mode), $urandom_range(3) != 0, rnd(), $urandom_range(3) == 0,
                      $urandom_range(3) != 0, $urandom_range(1) == 1, acc);
            end
        end
        idle('0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
